// File: rtl/logic_unit_arbiter_if.sv
// Handshake bundle between two issue ports, the shared logic unit arbiter and
// the response consumer.
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [2:0]       rsp_op;
    logic [WIDTH-1:0] rsp_data;

    logic [CNT_W-1:0] acc_cnt0;
    logic [CNT_W-1:0] acc_cnt1;

    // Requester/consumer side of the bundle.
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_op, rsp_data,
        input  acc_cnt0, acc_cnt1
    );

    // Arbiter side of the bundle.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_op, rsp_data,
        output acc_cnt0, acc_cnt1
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters,
// with a single-entry registered response slot that supports backpressure.
module logic_unit_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_unit_arbiter_if.slave  bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             rsp_id_q, rsp_id_d;
    logic [2:0]       rsp_op_q, rsp_op_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] acc_cnt0_q, acc_cnt0_d;
    logic [CNT_W-1:0] acc_cnt1_q, acc_cnt1_d;

    logic             can_accept;
    logic             grant_id;
    logic             ready0, ready1;
    logic             accept0, accept1;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;

    function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    logic_fn = a & b;
            3'd1:    logic_fn = a | b;
            3'd2:    logic_fn = ~a;
            3'd3:    logic_fn = ~b;
            3'd4:    logic_fn = ~(a & b);
            3'd5:    logic_fn = ~(a | b);
            3'd6:    logic_fn = a ^ b;
            default: logic_fn = ~(a ^ b);
        endcase
    endfunction

    // Under contention the requester that did not win last time is favoured;
    // readies are held low during reset so nothing is taken then.
    always_comb begin
        can_accept = (state_q == EMPTY) || bus.rsp_ready;
        grant_id   = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
        ready0     = !rst && can_accept && bus.req0_valid && (grant_id == 1'b0);
        ready1     = !rst && can_accept && bus.req1_valid && (grant_id == 1'b1);
        accept0    = bus.req0_valid && ready0;
        accept1    = bus.req1_valid && ready1;
        sel_op     = accept1 ? bus.req1_op : bus.req0_op;
        sel_a      = accept1 ? bus.req1_a  : bus.req0_a;
        sel_b      = accept1 ? bus.req1_b  : bus.req0_b;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_op_d     = rsp_op_q;
        rsp_data_d   = rsp_data_q;
        acc_cnt0_d   = acc_cnt0_q + {{(CNT_W-1){1'b0}}, accept0};
        acc_cnt1_d   = acc_cnt1_q + {{(CNT_W-1){1'b0}}, accept1};
        if (accept0 || accept1) begin
            state_d      = FULL;
            last_grant_d = accept1;
            rsp_id_d     = accept1;
            rsp_op_d     = sel_op;
            rsp_data_d   = logic_fn(sel_op, sel_a, sel_b);
        end else if (state_q == FULL && bus.rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_op_q     <= 3'd0;
            rsp_data_q   <= '0;
            acc_cnt0_q   <= '0;
            acc_cnt1_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_op_q     <= rsp_op_d;
            rsp_data_q   <= rsp_data_d;
            acc_cnt0_q   <= acc_cnt0_d;
            acc_cnt1_q   <= acc_cnt1_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = (state_q == FULL);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_op     = rsp_op_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.acc_cnt0   = acc_cnt0_q;
    assign bus.acc_cnt1   = acc_cnt1_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: handshake, opcode map, fairness,
// backpressure, reset and counter wrap (second instance with CNT_W=2).
module tb_logic_unit_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic_unit_arbiter_if #(.WIDTH(8), .CNT_W(8)) bus ();
    logic_unit_arbiter_if #(.WIDTH(8), .CNT_W(2)) wbus ();

    logic_unit_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic_unit_arbiter #(.WIDTH(8), .CNT_W(2)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_exp [8];
    logic [1:0] wrap_exp [5];

    initial begin
        total = 0;
        bad   = 0;
        sweep_exp = '{8'h05, 8'hAF, 8'h5A, 8'hF0, 8'hFA, 8'h50, 8'hAA, 8'h55};
        wrap_exp  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
        bus.rsp_ready  = 1'b1;
        wbus.req0_valid = 1'b0; wbus.req0_op = 3'd0; wbus.req0_a = 8'hFF; wbus.req0_b = 8'hFF;
        wbus.req1_valid = 1'b0; wbus.req1_op = 3'd0; wbus.req1_a = 8'h00; wbus.req1_b = 8'h00;
        wbus.rsp_ready  = 1'b1;
        step();
        bus.req0_valid = 1'b1;
        #1;
        checkOutput("ready0_in_reset", bus.req0_ready, 0);
        step();
        bus.req0_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
        checkOutput("reset_rsp_id", bus.rsp_id, 0);
        checkOutput("reset_rsp_op", bus.rsp_op, 0);
        checkOutput("reset_rsp_data", bus.rsp_data, 0);
        checkOutput("reset_cnt0", bus.acc_cnt0, 0);
        checkOutput("reset_cnt1", bus.acc_cnt1, 0);

        // single request on requester 0: F0 & 3C = 30
        bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = 8'hF0; bus.req0_b = 8'h3C;
        #1;
        checkOutput("t1_ready0", bus.req0_ready, 1);
        checkOutput("t1_ready1", bus.req1_ready, 0);
        step();
        bus.req0_valid = 1'b0;
        checkOutput("t1_rsp_valid", bus.rsp_valid, 1);
        checkOutput("t1_rsp_id", bus.rsp_id, 0);
        checkOutput("t1_rsp_data", bus.rsp_data, 8'h30);
        checkOutput("t1_cnt0", bus.acc_cnt0, 1);
        step();
        checkOutput("t1_drained", bus.rsp_valid, 0);
        checkOutput("t1_data_hold", bus.rsp_data, 8'h30);

        // opcode sweep on requester 1, back to back
        bus.req1_valid = 1'b1; bus.req1_a = 8'hA5; bus.req1_b = 8'h0F;
        for (int op = 0; op < 8; op++) begin
            bus.req1_op = 3'(op);
            #1;
            checkOutput($sformatf("sweep_ready1_op%0d", op), bus.req1_ready, 1);
            step();
            checkOutput($sformatf("sweep_valid_op%0d", op), bus.rsp_valid, 1);
            checkOutput($sformatf("sweep_id_op%0d", op), bus.rsp_id, 1);
            checkOutput($sformatf("sweep_data_op%0d", op), bus.rsp_data, sweep_exp[op]);
        end
        bus.req1_valid = 1'b0;
        step();
        checkOutput("sweep_cnt1", bus.acc_cnt1, 8);

        // contention: req0 -> FF & 0F = 0F, req1 -> F0 | 01 = F1
        bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = 8'hFF; bus.req0_b = 8'h0F;
        bus.req1_valid = 1'b1; bus.req1_op = 3'd1; bus.req1_a = 8'hF0; bus.req1_b = 8'h01;
        for (int i = 0; i < 6; i++) begin
            #1;
            checkOutput($sformatf("rr_both_ready_%0d", i), bus.req0_ready & bus.req1_ready, 0);
            step();
            checkOutput($sformatf("rr_id_%0d", i), bus.rsp_id, i % 2);
            checkOutput($sformatf("rr_data_%0d", i), bus.rsp_data, (i % 2) ? 8'hF1 : 8'h0F);
        end
        checkOutput("rr_cnt0", bus.acc_cnt0, 4);
        checkOutput("rr_cnt1", bus.acc_cnt1, 11);

        // backpressure: accept 3C ^ 0F = 33, then stall with both valid
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        step();
        bus.req0_valid = 1'b1; bus.req0_op = 3'd6; bus.req0_a = 8'h3C; bus.req0_b = 8'h0F;
        #1;
        checkOutput("bp_ready0", bus.req0_ready, 1);
        step();
        bus.rsp_ready = 1'b0;
        bus.req0_op = 3'd7; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
        bus.req1_valid = 1'b1; bus.req1_op = 3'd5; bus.req1_a = 8'h0F; bus.req1_b = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput($sformatf("bp_ready0_%0d", i), bus.req0_ready, 0);
            checkOutput($sformatf("bp_ready1_%0d", i), bus.req1_ready, 0);
            step();
            checkOutput($sformatf("bp_valid_%0d", i), bus.rsp_valid, 1);
            checkOutput($sformatf("bp_id_%0d", i), bus.rsp_id, 0);
            checkOutput($sformatf("bp_op_%0d", i), bus.rsp_op, 6);
            checkOutput($sformatf("bp_data_%0d", i), bus.rsp_data, 8'h33);
        end
        bus.rsp_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready1", bus.req1_ready, 1);
        checkOutput("bp_release_ready0", bus.req0_ready, 0);
        step();
        checkOutput("bp_nobubble_valid", bus.rsp_valid, 1);
        checkOutput("bp_nobubble_id", bus.rsp_id, 1);
        checkOutput("bp_nobubble_data", bus.rsp_data, 8'h00);
        checkOutput("bp_cnt1", bus.acc_cnt1, 12);
        step();
        checkOutput("bp_next_id", bus.rsp_id, 0);
        checkOutput("bp_next_data", bus.rsp_data, 8'hFF);
        checkOutput("bp_cnt0", bus.acc_cnt0, 6);

        // reset mid-operation with response pending and both valid
        rst = 1'b1;
        #1;
        checkOutput("rst_ready0", bus.req0_ready, 0);
        checkOutput("rst_ready1", bus.req1_ready, 0);
        step();
        checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("rst_cnt0", bus.acc_cnt0, 0);
        checkOutput("rst_cnt1", bus.acc_cnt1, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready0", bus.req0_ready, 1);
        checkOutput("post_rst_ready1", bus.req1_ready, 0);
        step();
        checkOutput("post_rst_id", bus.rsp_id, 0);
        checkOutput("post_rst_data", bus.rsp_data, 8'hFF);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        // counter wrap on the CNT_W=2 instance
        wbus.req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("wrap_cnt0_%0d", i), wbus.acc_cnt0, wrap_exp[i]);
        end
        wbus.req0_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one bitwise logic unit (AND, OR, NOT A, NOT B, NAND, NOR, XOR, XNOR) between two requesters. Each requester uses a valid/ready handshake. The block grants one request per cycle by round-robin, computes the selected gate function on WIDTH-bit operands, and returns the result through a single-entry registered response port with backpressure. It sits between the ALU front-end issue ports and the shared logic datapath.

## Interface
- WIDTH, 8, operand and result width in bits
- CNT_W, 8, width of the per-requester accept counters

- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this cycle when high together with req0_valid
- req0_op  input  3  requester 0 opcode
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- rsp_valid  output  1  response register holds a result
- rsp_ready  input  1  consumer accepts the response
- rsp_id  output  1  requester index that owns the response
- rsp_op  output  3  opcode of the response
- rsp_data  output  WIDTH  result
- acc_cnt0, acc_cnt1  output  CNT_W  accepted-request count per requester, wraps modulo 2^CNT_W

## Operation
- Opcode map, bitwise on WIDTH bits:
  - 0 AND
  - 1 OR
  - 2 ~a
  - 3 ~b
  - 4 NAND
  - 5 NOR
  - 6 XOR
  - 7 XNOR
- Opcodes 2 and 3 ignore the other operand.
- can_accept = !rsp_valid || rsp_ready. The response slot is empty, or is being drained this cycle.
- Arbitration, with last_grant as a 1-bit state register:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - Neither valid: no grant.
- reqN_ready = can_accept && grant==N. The ready signals are combinational.
- A requester may see ready high only when it is granted. Both ready signals are never high in the same cycle.
- Accept is reqN_valid && reqN_ready. On accept:
  - rsp_data <= f(op, a, b)
  - rsp_op <= op
  - rsp_id <= N
  - rsp_valid <= 1
  - last_grant <= N
  - acc_cntN <= acc_cntN + 1
- A response is drained when rsp_valid && rsp_ready.
  - If there is no accept in the same cycle, rsp_valid <= 0. rsp_data, rsp_op and rsp_id hold their last value.
  - Drain and accept in the same cycle: the register loads the new result and rsp_valid stays 1. There is no bubble.
- While the response is stalled (rsp_valid && !rsp_ready):
  - Both ready signals are low.
  - rsp_* outputs are held stable.
  - last_grant is unchanged.
- Requesters hold op, a and b stable while valid is high and ready is low. Dropping valid before accept is legal; the request is simply not taken.
- Fairness: under continuous contention with rsp_ready=1, grants alternate 0,1,0,1. Neither requester waits more than one accepted request from the other.
- The counters wrap from 2^CNT_W-1 to 0 with no flag.
- Control FSM, with the state equal to rsp_valid:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with drain, or on stall.
  - FULL -> EMPTY on drain with no accept.

## Timing
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_op=0, rsp_data=0
  - acc_cnt0=0, acc_cnt1=0
  - last_grant=1, so requester 0 wins the first contention
- In the reset cycle, req0_ready and req1_ready are forced to 0.
- Reset asserted mid-operation discards any pending response in the next cycle. Requests presented during reset are not accepted.
- Latency: accept on cycle N gives rsp_valid=1 with the result visible in cycle N+1.
- Throughput: one request per cycle while rsp_ready=1.
- The response path is fully registered. Only reqN_ready is combinational from reqN_valid, rsp_valid and rsp_ready.

## Test plan
- Reset, then idle: all outputs 0. req0_valid=1 with op=0, a=8'hF0, b=8'h3C -> req0_ready=1 in that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=8'h30, acc_cnt0=1.
- Opcode sweep on requester 1 with a=8'hA5, b=8'h0F and rsp_ready=1, ops 0..7 back to back -> 8'h05, 8'hAF, 8'h5A, 8'hF0, 8'hFA, 8'h50, 8'hAA, 8'h55. Results arrive on consecutive cycles with no bubble.
- Both requesters valid continuously with rsp_ready=1 for 6 cycles -> rsp_id sequence 0,1,0,1,0,1; acc_cnt0=3, acc_cnt1=3.
- Backpressure: accept one request, then hold rsp_ready=0 for 4 cycles with both requesters valid -> both ready signals stay 0 and rsp_* is stable. Release rsp_ready -> the drain and the next accept happen in the same cycle, and rsp_valid stays 1.
- Assert rst while rsp_valid=1 and both requesters valid -> next cycle rsp_valid=0, counters 0, no accept during reset. After reset, first contention grants requester 0.
- Counter wrap with CNT_W=2: 5 requester-0 accepts -> acc_cnt0 goes 1,2,3,0,1.
